// File: rtl/wb_stage_pkg.sv
// Shared types and encodings for the RV32IM writeback stage.
// Holds writeback-source and load funct3 encodings plus the MEM/WB bundle.
package wb_stage_pkg;

    localparam int XLEN = 32;

    // Writeback source select; 2'b11 is reserved and behaves as ALU.
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    // Load width/sign encodings (instruction funct3).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Owner of the register file write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_PIPE,
        GNT_MD
    } grant_e;

    // MEM/WB pipeline register contents.
    typedef struct packed {
        logic            valid;
        logic            reg_we;
        logic [4:0]      rd;
        logic [1:0]      wb_sel;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] load_data;
        logic [2:0]      funct3;
        logic [1:0]      addr_lo;
    } mem_wb_t;

    // Extend a byte to XLEN, sign-extending when sgn is set.
    function automatic logic [XLEN-1:0] ext8(
        input logic [7:0] b,
        input logic       sgn
    );
        return {{(XLEN-8){sgn & b[7]}}, b};
    endfunction

    // Extend a halfword to XLEN, sign-extending when sgn is set.
    function automatic logic [XLEN-1:0] ext16(
        input logic [15:0] h,
        input logic        sgn
    );
        return {{(XLEN-16){sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Mul/div completion handshake into the writeback stage.
// master: mul/div unit (drives valid/rd/result); slave: wb_stage (drives ready).
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic            md_valid;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_result;
    logic            md_ready;

    modport master (
        output md_valid,
        output md_rd,
        output md_result,
        input  md_ready
    );

    modport slave (
        input  md_valid,
        input  md_rd,
        input  md_result,
        output md_ready
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: picks byte/half by address and extends it.
// Ports: word_i raw aligned word, funct3_i width/sign, addr_lo_i offset, data_o.
module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // addr_lo_i[0] is ignored for halves; misalignment traps upstream.
    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            F3_LB:   data_o = ext8(byte_sel, 1'b1);
            F3_LBU:  data_o = ext8(byte_sel, 1'b0);
            F3_LH:   data_o = ext16(half_sel, 1'b1);
            F3_LHU:  data_o = ext16(half_sel, 1'b0);
            F3_LW:   data_o = word_i;
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32IM writeback stage: MEM/WB register, load formatting and
// arbitration of the register file write port between pipe and mul/div.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_*             instruction leaving MEM, captured unless wb_stall
//   md (slave)        mul/div completion valid/ready handshake
//   rf_we/rd_addr/    register file write port; rf_rd_data also feeds
//   rf_rd_data        the WB forwarding bypass
//   wb_stall          MEM/WB holds and upstream freezes this cycle
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            mem_valid,
    input  logic            mem_reg_we,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_pc4,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,

    wb_stage_if.slave       md,

    output logic            rf_we,
    output logic [4:0]      rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_data,
    output logic            wb_stall
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mem_wb_t         wb_d;
    mem_wb_t         wb_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    logic            pw;
    logic            starve;
    logic            md_ready_w;
    grant_e          grant;
    logic [XLEN-1:0] load_fmt;
    logic [XLEN-1:0] pipe_data;

    // ---------------------------------------------------------------
    // MEM/WB register and starvation counter
    // ---------------------------------------------------------------
    always_comb begin
        wb_d            = '0;
        wb_d.valid      = mem_valid;
        wb_d.reg_we     = mem_reg_we;
        wb_d.rd         = mem_rd;
        wb_d.wb_sel     = mem_wb_sel;
        wb_d.alu_result = mem_alu_result;
        wb_d.pc4        = mem_pc4;
        wb_d.load_data  = mem_load_data;
        wb_d.funct3     = mem_funct3;
        wb_d.addr_lo    = mem_addr_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (!wb_stall) begin
                wb_q <= wb_d;
            end
            cnt_q <= cnt_d;
        end
    end

    // ---------------------------------------------------------------
    // Pipe-side write data
    // ---------------------------------------------------------------
    wb_stage_load_align u_load_align (
        .word_i    (wb_q.load_data),
        .funct3_i  (wb_q.funct3),
        .addr_lo_i (wb_q.addr_lo),
        .data_o    (load_fmt)
    );

    always_comb begin
        pipe_data = wb_q.alu_result;
        case (wb_q.wb_sel)
            WB_SEL_LOAD: pipe_data = load_fmt;
            WB_SEL_PC4:  pipe_data = wb_q.pc4;
            WB_SEL_ALU:  pipe_data = wb_q.alu_result;
            default:     pipe_data = wb_q.alu_result;
        endcase
    end

    // ---------------------------------------------------------------
    // Write port arbitration
    // ---------------------------------------------------------------
    assign pw     = wb_q.valid & wb_q.reg_we & (wb_q.rd != 5'd0);
    assign starve = (cnt_q >= LIMIT);

    // Pipe normally wins; a starved mul/div result steals one slot and
    // holds the pipe instruction so it retries the next cycle.
    always_comb begin
        grant    = GNT_IDLE;
        wb_stall = 1'b0;
        if (md.md_valid && starve && pw) begin
            grant    = GNT_MD;
            wb_stall = 1'b1;
        end else if (pw) begin
            grant = GNT_PIPE;
        end else if (md.md_valid) begin
            grant = GNT_MD;
        end
    end

    assign md_ready_w  = (grant == GNT_MD);
    assign md.md_ready = md_ready_w;

    // Idle cycles still present the pipe values for the bypass path.
    always_comb begin
        rf_we      = 1'b0;
        rf_rd_addr = wb_q.rd;
        rf_rd_data = pipe_data;
        case (grant)
            GNT_PIPE: begin
                rf_we = 1'b1;
            end
            GNT_MD: begin
                rf_we      = (md.md_rd != 5'd0);
                rf_rd_addr = md.md_rd;
                rf_rd_data = md.md_result;
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
    end

    // Counts cycles a completion waits unserved; a grant resets it.
    always_comb begin
        cnt_d = cnt_q;
        if (md.md_valid && md_ready_w) begin
            cnt_d = '0;
        end else if (md.md_valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a random run
// compared against a cycle-level behavioural model of the stage.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int LIMIT = 4;
    localparam int CMAX  = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_reg_we;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_pc4;
    logic [31:0] mem_load_data;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        wb_stall;

    wb_stage_if mdif ();

    wb_stage #(
        .STARVE_LIMIT (4),
        .CNT_W        (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_reg_we     (mem_reg_we),
        .mem_rd         (mem_rd),
        .mem_wb_sel     (mem_wb_sel),
        .mem_alu_result (mem_alu_result),
        .mem_pc4        (mem_pc4),
        .mem_load_data  (mem_load_data),
        .mem_funct3     (mem_funct3),
        .mem_addr_lo    (mem_addr_lo),
        .md             (mdif),
        .rf_we          (rf_we),
        .rf_rd_addr     (rf_rd_addr),
        .rf_rd_data     (rf_rd_data),
        .wb_stall       (wb_stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model of the instruction sitting in writeback and of the wait count.
    logic        m_valid, m_we;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [31:0] m_alu, m_pc4, m_ld;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;
    int          m_wait;

    logic        e_we, e_ready, e_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    function automatic logic [31:0] fmt_load(
        input logic [31:0] w,
        input logic [2:0]  f3,
        input logic [1:0]  lo
    );
        logic [31:0] b;
        logic [31:0] h;
        int          hs;
        hs = lo[1] ? 16 : 0;
        b = (w >> (8 * int'(lo))) & 32'hFF;
        h = (w >> hs) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Expected port values from the current model state and md inputs.
    task automatic compute_exp();
        logic        pw;
        logic [31:0] pdata;
        pw = m_valid && m_we && (m_rd != 5'd0);
        if (m_sel == 2'b01)      pdata = fmt_load(m_ld, m_f3, m_lo);
        else if (m_sel == 2'b10) pdata = m_pc4;
        else                     pdata = m_alu;
        e_we = 1'b0; e_ready = 1'b0; e_stall = 1'b0;
        e_addr = m_rd; e_data = pdata;
        if (mdif.md_valid && pw && m_wait >= LIMIT) begin
            e_ready = 1'b1; e_stall = 1'b1;
            e_we = (mdif.md_rd != 5'd0);
            e_addr = mdif.md_rd; e_data = mdif.md_result;
        end else if (pw) begin
            e_we = 1'b1;
        end else if (mdif.md_valid) begin
            e_ready = 1'b1;
            e_we = (mdif.md_rd != 5'd0);
            e_addr = mdif.md_rd; e_data = mdif.md_result;
        end
    endtask

    // One clock: advance the model with the inputs present at the edge.
    task automatic tick();
        compute_exp();
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_we = 0; m_rd = 0; m_sel = 0;
            m_alu = 0; m_pc4 = 0; m_ld = 0; m_f3 = 0; m_lo = 0;
            m_wait = 0;
        end else begin
            if (!e_stall) begin
                m_valid = mem_valid; m_we = mem_reg_we;
                m_rd = mem_rd; m_sel = mem_wb_sel;
                m_alu = mem_alu_result; m_pc4 = mem_pc4;
                m_ld = mem_load_data; m_f3 = mem_funct3;
                m_lo = mem_addr_lo;
            end
            if (mdif.md_valid && e_ready) m_wait = 0;
            else if (mdif.md_valid && m_wait < CMAX) m_wait++;
        end
        #1;
    endtask

    task automatic set_mem(
        input logic v, input logic we, input logic [4:0] rd,
        input logic [1:0] sel, input logic [31:0] alu,
        input logic [31:0] pc4, input logic [31:0] ld,
        input logic [2:0] f3, input logic [1:0] lo
    );
        mem_valid = v; mem_reg_we = we; mem_rd = rd;
        mem_wb_sel = sel; mem_alu_result = alu; mem_pc4 = pc4;
        mem_load_data = ld; mem_funct3 = f3; mem_addr_lo = lo;
    endtask

    task automatic set_md(
        input logic v, input logic [4:0] rd, input logic [31:0] res
    );
        mdif.md_valid = v; mdif.md_rd = rd; mdif.md_result = res;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_mem(1, 1, 5'd3, 2'b00, 32'h55, 32'h4, 32'h0, 3'b010, 2'b00);
        set_md(0, 5'd0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        set_mem(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL reset_we: got %b want 0", rf_we);
        end
        checks++;
        if (rf_rd_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d want 0", rf_rd_addr);
        end
        checks++;
        if (rf_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", rf_rd_data);
        end
        checks++;
        if (mdif.md_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", mdif.md_ready);
        end
        checks++;
        if (wb_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b want 0", wb_stall);
        end
        tick();
    endtask

    task automatic test_load_format();
        logic [2:0]  f3 [8];
        logic [1:0]  lo [8];
        logic [31:0] ex [8];
        f3 = '{3'b000, 3'b100, 3'b001, 3'b101,
               3'b010, 3'b000, 3'b001, 3'b111};
        lo = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
        ex = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
               32'h80FF7F01, 32'h0000007F, 32'hFFFF80FF, 32'h80FF7F01};
        for (int i = 0; i < 8; i++) begin
            set_mem(1, 1, 5'd3, 2'b01, 32'hA5A5A5A5, 32'h10,
                    32'h80FF7F01, f3[i], lo[i]);
            tick();
            checks++;
            if (rf_rd_data !== ex[i] || rf_we !== 1'b1) begin
                errors++;
                $display("FAIL load_%0d: we=%b data=%h want we=1 data=%h",
                         i, rf_we, rf_rd_data, ex[i]);
            end
        end
    endtask

    task automatic test_sources();
        set_mem(1, 1, 5'd5, 2'b00, 32'h1234, 32'h104, 32'h0, 3'b010, 2'd0);
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_rd_addr !== 5'd5 ||
            rf_rd_data !== 32'h1234) begin
            errors++;
            $display("FAIL alu_wr: we=%b addr=%0d data=%h want 1/5/1234",
                     rf_we, rf_rd_addr, rf_rd_data);
        end
        set_mem(1, 1, 5'd1, 2'b10, 32'h9999, 32'h104, 32'h0, 3'b010, 2'd0);
        tick();
        checks++;
        if (rf_rd_data !== 32'h104 || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL pc4: we=%b data=%h want 1/104", rf_we, rf_rd_data);
        end
        set_mem(1, 1, 5'd2, 2'b11, 32'h7777, 32'h104, 32'h0, 3'b010, 2'd0);
        tick();
        checks++;
        if (rf_rd_data !== 32'h7777) begin
            errors++;
            $display("FAIL sel_rsv: data=%h want 7777", rf_rd_data);
        end
        set_mem(1, 1, 5'd0, 2'b00, 32'h4321, 32'h104, 32'h0, 3'b010, 2'd0);
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL rd_x0: we=%b want 0", rf_we);
        end
        set_mem(1, 0, 5'd8, 2'b00, 32'h4321, 32'h104, 32'h0, 3'b010, 2'd0);
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL no_we: we=%b want 0", rf_we);
        end
    endtask

    task automatic test_md_bubble();
        set_mem(0, 1, 5'd4, 2'b00, 32'h1, 32'h0, 32'h0, 3'b010, 2'd0);
        tick();
        set_md(1, 5'd7, 32'hDEAD);
        #1;
        checks++;
        if (mdif.md_ready !== 1'b1 || rf_we !== 1'b1 ||
            rf_rd_addr !== 5'd7 || rf_rd_data !== 32'hDEAD ||
            wb_stall !== 1'b0) begin
            errors++;
            $display("FAIL md_bubble: rdy=%b we=%b a=%0d d=%h st=%b",
                     mdif.md_ready, rf_we, rf_rd_addr, rf_rd_data, wb_stall);
        end
        tick();
        set_md(0, 5'd0, 32'h0);
    endtask

    task automatic test_starvation();
        set_md(0, 5'd0, 32'h0);
        set_mem(1, 1, 5'd5, 2'b00, 32'h100, 32'h0, 32'h0, 3'b010, 2'd0);
        tick();
        set_md(1, 5'd9, 32'hBEEF);
        for (int i = 1; i <= 4; i++) begin
            set_mem(1, 1, 5'd5, 2'b00, 32'h100 + i, 32'h0, 32'h0,
                    3'b010, 2'd0);
            #1;
            checks++;
            if (mdif.md_ready !== 1'b0 || wb_stall !== 1'b0 ||
                rf_we !== 1'b1 || rf_rd_data !== 32'h100 + i - 1) begin
                errors++;
                $display("FAIL starve_wait%0d: rdy=%b st=%b we=%b d=%h",
                         i, mdif.md_ready, wb_stall, rf_we, rf_rd_data);
            end
            tick();
        end
        set_mem(1, 1, 5'd5, 2'b00, 32'h1FF, 32'h0, 32'h0, 3'b010, 2'd0);
        #1;
        checks++;
        if (mdif.md_ready !== 1'b1 || wb_stall !== 1'b1 || rf_we !== 1'b1 ||
            rf_rd_addr !== 5'd9 || rf_rd_data !== 32'hBEEF) begin
            errors++;
            $display("FAIL starve_grant: rdy=%b st=%b we=%b a=%0d d=%h",
                     mdif.md_ready, wb_stall, rf_we, rf_rd_addr, rf_rd_data);
        end
        tick();
        set_md(0, 5'd0, 32'h0);
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_rd_addr !== 5'd5 ||
            rf_rd_data !== 32'h104 || wb_stall !== 1'b0) begin
            errors++;
            $display("FAIL starve_retry: we=%b a=%0d d=%h st=%b want 1/5/104/0",
                     rf_we, rf_rd_addr, rf_rd_data, wb_stall);
        end
        tick();
        set_md(1, 5'd9, 32'hBEEF);
        #1;
        checks++;
        if (mdif.md_ready !== 1'b0 || wb_stall !== 1'b0) begin
            errors++;
            $display("FAIL starve_clear: rdy=%b st=%b want 0/0",
                     mdif.md_ready, wb_stall);
        end
        tick();
        set_md(0, 5'd0, 32'h0);
    endtask

    task automatic test_reset_mid_stall();
        bit seen;
        seen = 0;
        set_md(1, 5'd0, 32'h5A5A);
        for (int i = 0; i < 10 && !seen; i++) begin
            set_mem(1, 1, 5'd6, 2'b00, 32'hAAAA, 32'h0, 32'h0, 3'b010, 2'd0);
            #1;
            if (wb_stall === 1'b1) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rst_stall_seen: stall never 1 in 10");
        end
        rst = 1'b1;
        set_mem(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b010, 2'd0);
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || wb_stall !== 1'b0 ||
            mdif.md_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_stall: we=%b st=%b rdy=%b want 0/0/1",
                     rf_we, wb_stall, mdif.md_ready);
        end
        set_md(0, 5'd0, 32'h0);
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_rd_data === 32'hAAAA) begin
            errors++;
            $display("FAIL rst_discard: we=%b d=%h", rf_we, rf_rd_data);
        end
    endtask

    task automatic test_md_rd0();
        set_mem(1, 1, 5'd4, 2'b00, 32'h55, 32'h0, 32'h0, 3'b010, 2'd0);
        tick();
        set_mem(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b010, 2'd0);
        set_md(1, 5'd0, 32'h77);
        #1;
        checks++;
        if (mdif.md_ready !== 1'b0 || rf_we !== 1'b1 ||
            rf_rd_addr !== 5'd4 || rf_rd_data !== 32'h55) begin
            errors++;
            $display("FAIL rd0_pipe: rdy=%b we=%b a=%0d d=%h want 0/1/4/55",
                     mdif.md_ready, rf_we, rf_rd_addr, rf_rd_data);
        end
        tick();
        checks++;
        if (mdif.md_ready !== 1'b1 || rf_we !== 1'b0 ||
            wb_stall !== 1'b0) begin
            errors++;
            $display("FAIL rd0_consume: rdy=%b we=%b st=%b want 1/0/0",
                     mdif.md_ready, rf_we, wb_stall);
        end
        tick();
        set_md(0, 5'd0, 32'h0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_mem($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                    5'($urandom_range(0, 7)), 2'($urandom),
                    $urandom, $urandom, $urandom,
                    3'($urandom), 2'($urandom));
            set_md($urandom_range(0, 9) < 7, 5'($urandom_range(0, 3)),
                   $urandom);
            #1;
            compute_exp();
            checks++;
            if (rf_we !== e_we || rf_rd_addr !== e_addr ||
                rf_rd_data !== e_data) begin
                errors++;
                $display("FAIL rand_wr%0d: we=%b a=%0d d=%h want %b/%0d/%h",
                         c, rf_we, rf_rd_addr, rf_rd_data,
                         e_we, e_addr, e_data);
            end
            checks++;
            if (mdif.md_ready !== e_ready || wb_stall !== e_stall) begin
                errors++;
                $display("FAIL rand_hs%0d: rdy=%b st=%b want %b/%b",
                         c, mdif.md_ready, wb_stall, e_ready, e_stall);
            end
            tick();
        end
        rst = 1'b0;
        set_md(0, 5'd0, 32'h0);
    endtask

    initial begin
        m_valid = 0; m_we = 0; m_rd = 0; m_sel = 0;
        m_alu = 0; m_pc4 = 0; m_ld = 0; m_f3 = 0; m_lo = 0;
        m_wait = 0;
        test_reset();
        test_load_format();
        test_sources();
        test_md_bubble();
        test_starvation();
        test_reset_mid_stall();
        test_md_rd0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
